feature_feeder: RTL
===================

FEATURE_FEEDER -- requirements
Module: feature_feeder

Interface
REQ-001 Parameter FEAT_CNT, default 4: number of features per inference.
REQ-002 Parameter FEAT_BITS, default 4: width of one feature.
REQ-003 Parameter CLASS_CNT, default 4: number of classes; prediction width is $clog2(CLASS_CNT).
REQ-004 Parameter LATENCY, default 16, minimum 1: classifier cycles from core_rst deassertion to valid prediction.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  upstream feature word valid.
REQ-008 in_ready  output  1  feeder accepts feature word.
REQ-009 in_feature  input  FEAT_BITS  one feature, sent in order feature 0 first.
REQ-010 features  output  FEAT_CNT*FEAT_BITS  packed vector to classifier; feature i at bits [i*FEAT_BITS +: FEAT_BITS].
REQ-011 core_rst  output  1  restart to classifier; high while loading.
REQ-012 core_prediction  input  $clog2(CLASS_CNT)  classifier winner.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_class  output  $clog2(CLASS_CNT)  captured prediction.

Function
REQ-016 States: LOAD, RUN, HOLD; in_ready = (state==LOAD); core_rst = (state==LOAD); out_valid = (state==HOLD); all decoded from registered state only.
REQ-017 LOAD: feature index idx ($clog2(FEAT_CNT+1) bits) starts at 0; each edge with in_valid&&in_ready writes in_feature to slice idx of features and increments idx.
REQ-018 LOAD: acceptance with idx==FEAT_CNT-1 -> RUN at same edge; idx returns to 0; latency counter cleared to 0.
REQ-019 LOAD with in_valid low: no change to features, idx or state.
REQ-020 RUN: in_valid ignored (in_ready low); counter increments each edge; at edge where counter==LATENCY-1, out_class <= core_prediction and state -> HOLD.
REQ-021 Timing: last feature accepted at edge E0 -> out_valid high after edge E0+LATENCY; core_rst low for exactly LATENCY cycles before capture.
REQ-022 HOLD: out_class and features stable; out_valid&&out_ready at an edge -> LOAD; out_ready low holds HOLD indefinitely.
REQ-023 Upstream may present next feature while in HOLD; it is not accepted until the cycle after the handshake edge (in_ready low in HOLD).
REQ-024 features retains old contents for slices not yet overwritten in a new LOAD; no clearing between inferences.
REQ-025 Counter width $clog2(LATENCY+1); no wrap occurs in RUN.

Reset
REQ-026 rst high at an edge: state=LOAD, idx=0, counter=0, features=0, out_class=0; takes priority over all handshakes.
REQ-027 Outputs after reset: in_ready=1, core_rst=1, out_valid=0, out_class=0, features=0.
REQ-028 rst mid-LOAD, mid-RUN or in HOLD discards partial vector and pending result; no out_valid produced for it.

Configuration
REQ-029 Macro FEATURE_FEEDER_COUNT_EN defined: extra output inf_count, output, 16 bits, counts out_valid&&out_ready handshakes, reset to 0, wraps 65535->0.
REQ-030 Macro undefined: port inf_count absent; all other behaviour identical.

Verification (FEAT_CNT=4, FEAT_BITS=4, CLASS_CNT=4, LATENCY=3)
REQ-031 Reset then send 1,2,3,4 back-to-back with out_ready=1 -> features=16'h4321, core_rst low 3 cycles, out_valid one cycle with out_class=core_prediction at capture edge.
REQ-032 in_valid gapped (1, idle 2 cycles, 2, 3, idle, 4) -> idx holds across gaps, features=16'h4321, RUN entered only after 4th accept.
REQ-033 out_ready low for 5 cycles in HOLD -> out_valid and out_class stable 5 cycles, in_ready low, then LOAD one cycle after handshake.
REQ-034 rst asserted after 2 features, then 4 new features 5,6,7,8 -> features=16'h8765, single result, no result for aborted set.
REQ-035 rst asserted during RUN -> out_valid never rises, core_rst=1 and features=0 next cycle.
REQ-036 With FEATURE_FEEDER_COUNT_EN, three full inferences -> inf_count=3; forced value 65535 plus one handshake -> 0.

Source files
------------

// File: rtl/feature_feeder.sv
// Serial-to-parallel feature loader that restarts a classifier and captures its prediction after LATENCY cycles.
// Optional: define FEATURE_FEEDER_COUNT_EN to add the 16-bit inf_count handshake counter output.

module feature_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module feature_feeder #(
  parameter int FEAT_CNT  = 4,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 4,
  parameter int LATENCY   = 16,
  localparam int PRED_W   = $clog2(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_feature,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          core_rst,
  input  logic [PRED_W-1:0]             core_prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
`ifdef FEATURE_FEEDER_COUNT_EN
  output logic [15:0]                   inf_count,
`endif
  output logic [PRED_W-1:0]             out_class
);
  localparam int IDX_W = $clog2(FEAT_CNT + 1);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {LOAD, RUN, HOLD} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             acc, last_feat, cnt_done, out_hs;

  assign in_ready  = (state == LOAD);
  assign core_rst  = (state == LOAD);
  assign out_valid = (state == HOLD);
  assign acc       = in_valid && in_ready;
  assign last_feat = (idx == LAST_IDX);
  assign cnt_done  = (cnt == CNT_LAST);
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (acc && last_feat) state_nx = RUN;
      RUN:     if (cnt_done)         state_nx = HOLD;
      HOLD:    if (out_hs)           state_nx = LOAD;
      default:                       state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      cnt       <= '0;
      out_class <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: if (acc) begin
          idx <= last_feat ? '0 : idx + IDX_W'(1);
          if (last_feat) cnt <= '0;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt_done) out_class <= core_prediction;
        end
        default: ;
      endcase
    end
  end

  // One slot per feature; slots not rewritten keep their previous value.
  for (genvar i = 0; i < FEAT_CNT; i++) begin : g_slot
    feature_slot #(.W(FEAT_BITS)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  (acc && (idx == IDX_W'(i))),
      .d   (in_feature),
      .q   (features[i*FEAT_BITS +: FEAT_BITS])
    );
  end

`ifdef FEATURE_FEEDER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)         inf_count <= '0;
    else if (out_hs) inf_count <= inf_count + 16'd1;
  end
`endif
endmodule
